// File: rtl/mem_arbiter_pkg.sv
// Shared identifiers, types and helpers for the two-master memory arbiter.
package mem_arbiter_pkg;

   localparam logic ID_M0      = 1'b0;
   localparam logic ID_M1      = 1'b1;
   localparam int   PRIO_RR    = 0;
   localparam int   PRIO_FIXED = 1;
   localparam int   CONSEC_W   = 4;

   typedef enum logic [1:0] {
      WIN_NONE = 2'd0,
      WIN_M0   = 2'd1,
      WIN_M1   = 2'd2
   } win_e;

   typedef struct packed {
      logic [31:0] addr;
      logic        rstrb;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } mem_req_t;

   function automatic logic [CONSEC_W-1:0] sat_inc(input logic [CONSEC_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/mem_arbiter_arb2.sv
// Two-way grant decision with last-winner (round-robin) and consecutive-M1
// (fixed priority) state. The decision is combinational on the registered state.
module mem_arbiter_arb2
   import mem_arbiter_pkg::*;
#(
   parameter int PRIO_MODE  = PRIO_FIXED,
   parameter int MAX_CONSEC = 4
) (
   input  logic clk,
   input  logic resetn,
   input  logic i_req0,
   input  logic i_req1,
   output win_e o_win,
   output logic o_gnt0,
   output logic o_gnt1
);

   logic                r_last;
   logic [CONSEC_W-1:0] r_consec;
   win_e                w_win;
   logic                w_m0_turn;

   always_comb begin
      w_m0_turn = 1'b0;
      if (PRIO_MODE == PRIO_RR)
         w_m0_turn = (r_last == ID_M1);
      else
         w_m0_turn = (r_consec >= CONSEC_W'(MAX_CONSEC));
   end

   always_comb begin
      w_win = WIN_NONE;
      if (resetn) begin
         if (i_req0 && i_req1)
            w_win = w_m0_turn ? WIN_M0 : WIN_M1;
         else if (i_req0)
            w_win = WIN_M0;
         else if (i_req1)
            w_win = WIN_M1;
      end
   end

   // consec only counts M1 grants that actually kept M0 waiting
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_last   <= ID_M1;
         r_consec <= '0;
      end else begin
         if (w_win == WIN_M0)
            r_last <= ID_M0;
         else if (w_win == WIN_M1)
            r_last <= ID_M1;

         if (!i_req0 || w_win == WIN_M0)
            r_consec <= '0;
         else if (w_win == WIN_M1)
            r_consec <= sat_inc(r_consec);
      end
   end

   assign o_win  = w_win;
   assign o_gnt0 = (w_win == WIN_M0);
   assign o_gnt1 = (w_win == WIN_M1);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch (M0) and load/store (M1);
// muxes the winner onto mem_* and tags read responses one cycle later.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int PRIO_MODE  = PRIO_FIXED,
   parameter int MAX_CONSEC = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        m0_req,
   input  logic [31:0] m0_addr,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic [31:0] m1_addr,
   input  logic        m1_rstrb,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wmask,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,
   output logic [31:0] mem_addr,
   output logic        mem_rstrb,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic [31:0] mem_rdata
);

   win_e     w_win;
   logic     w_gnt0;
   logic     w_gnt1;
   mem_req_t w_m0;
   mem_req_t w_m1;
   mem_req_t w_sel;
   logic     r_m0_rvalid;
   logic     r_m1_rvalid;

   mem_arbiter_arb2 #(
      .PRIO_MODE  (PRIO_MODE),
      .MAX_CONSEC (MAX_CONSEC)
   ) u_arb (
      .clk    (clk),
      .resetn (resetn),
      .i_req0 (m0_req),
      .i_req1 (m1_req),
      .o_win  (w_win),
      .o_gnt0 (w_gnt0),
      .o_gnt1 (w_gnt1)
   );

   // M0 is read-only; its store fields are tied off and wdata follows M1
   assign w_m0 = '{addr: m0_addr, rstrb: 1'b1, wdata: m1_wdata, wmask: 4'h0};
   assign w_m1 = '{addr: m1_addr, rstrb: m1_rstrb, wdata: m1_wdata, wmask: m1_wmask};

   always_comb begin
      w_sel       = w_m1;
      w_sel.rstrb = 1'b0;
      w_sel.wmask = 4'h0;
      case (w_win)
         WIN_M0:  w_sel = w_m0;
         WIN_M1:  w_sel = w_m1;
         default: ;
      endcase
   end

   assign mem_addr  = w_sel.addr;
   assign mem_rstrb = w_sel.rstrb;
   assign mem_wdata = w_sel.wdata;
   assign mem_wmask = w_sel.wmask;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_m0_rvalid <= 1'b0;
         r_m1_rvalid <= 1'b0;
      end else begin
         r_m0_rvalid <= w_gnt0;
         r_m1_rvalid <= w_gnt1 && m1_rstrb;
      end
   end

   assign m0_gnt    = w_gnt0;
   assign m1_gnt    = w_gnt1;
   assign m0_rvalid = r_m0_rvalid;
   assign m1_rvalid = r_m1_rvalid;
   assign m0_rdata  = mem_rdata;
   assign m1_rdata  = mem_rdata;

endmodule
